inst_fetch_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register feeding the control unit and register-file decode.
- Holds the PC and issues word fetches to instruction memory over a ready handshake.
- Presents the registered instruction, its 6-bit opcode and PC+4 to decode.
- Handles decode stalls through a 1-entry skid buffer, and branch/jump redirects by flushing.

---
 rtl/inst_fetch_stage.sv | 134 +++++++++++++
 tb/tb_inst_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_stage.sv
// Fetch stage with IF/ID pipeline register: owns the PC, fetches over a ready
// handshake, absorbs one decode stall through a skid entry, flushes on redirect.
//
// state | meaning
// ------+-----------------------------------------------------------
// START | first cycle after reset, no fetch issued
// REQ   | fetch request to imem at pc; skid entry empty
// HOLD  | skid entry full (word fetched under stall); no request
module inst_fetch_stage #(
    parameter int unsigned      PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP_INST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic            if_valid,
    output logic [31:0]     if_inst,
    output logic [5:0]      if_opcode,
    output logic [PC_W-1:0] if_pc4
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
    localparam logic [PC_W-1:0] PC_ALIGN = ~PC_W'(3);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_inst_q, if_inst_d;
    logic [5:0]      if_opcode_q, if_opcode_d;
    logic [PC_W-1:0] if_pc4_q, if_pc4_d;
    logic [31:0]     skid_inst_q, skid_inst_d;
    logic [PC_W-1:0] skid_pc4_q, skid_pc4_d;

    logic            accept;
    logic [PC_W-1:0] pc_plus4;

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;
    assign pc_plus4  = pc_q + PC_STEP;

    assign if_valid  = if_valid_q;
    assign if_inst   = if_inst_q;
    assign if_opcode = if_opcode_q;
    assign if_pc4    = if_pc4_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_inst_d   = if_inst_q;
        if_opcode_d = if_opcode_q;
        if_pc4_d    = if_pc4_q;
        skid_inst_d = skid_inst_q;
        skid_pc4_d  = skid_pc4_q;

        if (redirect) begin
            // The skid entry is dropped simply by leaving HOLD; its data is stale.
            pc_d        = redirect_pc & PC_ALIGN;
            if_valid_d  = 1'b0;
            if_inst_d   = NOP_INST;
            if_opcode_d = 6'd0;
            state_d     = ST_REQ;
        end else begin
            case (state_q)
                ST_START: state_d = ST_REQ;
                ST_REQ: begin
                    if (accept && !stall) begin
                        if_valid_d  = 1'b1;
                        if_inst_d   = imem_rdata;
                        if_opcode_d = imem_rdata[31:26];
                        if_pc4_d    = pc_plus4;
                        pc_d        = pc_plus4;
                    end else if (accept) begin
                        skid_inst_d = imem_rdata;
                        skid_pc4_d  = pc_plus4;
                        pc_d        = pc_plus4;
                        state_d     = ST_HOLD;
                    end else if (!stall) begin
                        if_valid_d  = 1'b0;
                        if_inst_d   = NOP_INST;
                        if_opcode_d = 6'd0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if_valid_d  = 1'b1;
                        if_inst_d   = skid_inst_q;
                        if_opcode_d = skid_inst_q[31:26];
                        if_pc4_d    = skid_pc4_q;
                        state_d     = ST_REQ;
                    end
                end
                default: state_d = ST_START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_START;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_inst_q   <= NOP_INST;
            if_opcode_q <= 6'd0;
            if_pc4_q    <= '0;
            skid_inst_q <= NOP_INST;
            skid_pc4_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_inst_q   <= if_inst_d;
            if_opcode_q <= if_opcode_d;
            if_pc4_q    <= if_pc4_d;
            skid_inst_q <= skid_inst_d;
            skid_pc4_q  <= skid_pc4_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed vector table, hand sequences for reset
// and 8-bit PC wrap, then random stimulus against a queue-based fetch model.
module tb_inst_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall, redirect, imem_ready;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [5:0]  if_opcode;
    logic [31:0] if_pc4;

    logic        stall8, redirect8, imem_ready8;
    logic [7:0]  redirect_pc8;
    logic        imem_req8;
    logic [7:0]  imem_addr8;
    logic [31:0] imem_rdata8;
    logic        if_valid8;
    logic [31:0] if_inst8;
    logic [5:0]  if_opcode8;
    logic [7:0]  if_pc48;

    // Memory image: word at byte address a is (a/4) + 0x100.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'h100;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata8 = mem_word({24'h0, imem_addr8});

    inst_fetch_stage #(.PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .if_valid(if_valid),
        .if_inst(if_inst), .if_opcode(if_opcode), .if_pc4(if_pc4)
    );

    inst_fetch_stage #(.PC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .stall(stall8), .redirect(redirect8),
        .redirect_pc(redirect_pc8), .imem_req(imem_req8), .imem_addr(imem_addr8),
        .imem_rdata(imem_rdata8), .imem_ready(imem_ready8), .if_valid(if_valid8),
        .if_inst(if_inst8), .if_opcode(if_opcode8), .if_pc4(if_pc48)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc4;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic rdy, input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] inst, input logic [31:0] pc4);
        vec_t x;
        x.stall = s; x.redir = r; x.rpc = rpc; x.ready = rdy;
        x.exp_req = req; x.exp_addr = addr;
        x.exp_valid = v; x.exp_inst = inst; x.exp_pc4 = pc4;
        return x;
    endfunction

    // Reference model: pending fetched-but-undelivered words live in a queue.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } entry_t;

    bit          m_started;
    logic [31:0] m_pc;
    entry_t      m_skid[$];
    logic        m_valid;
    logic [31:0] m_inst, m_pc4;

    function automatic logic m_req();
        return m_started && (m_skid.size() == 0);
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_pc      = 32'h0;
        m_skid.delete();
        m_valid   = 1'b0;
        m_inst    = 32'h0;
        m_pc4     = 32'h0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] rpc,
                              input logic rdy);
        entry_t e;
        if (r) begin
            m_pc      = rpc & ~32'h3;
            m_valid   = 1'b0;
            m_inst    = 32'h0;
            m_skid.delete();
            m_started = 1;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_skid.size() != 0) begin
            if (!s) begin
                e       = m_skid.pop_front();
                m_inst  = e.inst;
                m_pc4   = e.pc4;
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            e.inst = mem_word(m_pc);
            e.pc4  = m_pc + 32'd4;
            if (s) m_skid.push_back(e);
            else begin
                m_inst  = e.inst;
                m_pc4   = e.pc4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_valid = 1'b0;
            m_inst  = 32'h0;
        end
    endtask

    vec_t tbl[21];
    logic [31:0] rpc_r;

    initial begin
        tbl[0]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0);
        tbl[1]  = mk(0, 0, 32'h0,        1, 1, 32'h0,        1, 32'h100,      32'h4);
        tbl[2]  = mk(0, 0, 32'h0,        1, 1, 32'h4,        1, 32'h101,      32'h8);
        tbl[3]  = mk(0, 0, 32'h0,        0, 1, 32'h8,        0, 32'h0,        32'h8);
        tbl[4]  = mk(0, 0, 32'h0,        0, 1, 32'h8,        0, 32'h0,        32'h8);
        tbl[5]  = mk(0, 0, 32'h0,        1, 1, 32'h8,        1, 32'h102,      32'hC);
        tbl[6]  = mk(1, 0, 32'h0,        1, 1, 32'hC,        1, 32'h102,      32'hC);
        tbl[7]  = mk(1, 0, 32'h0,        1, 0, 32'h10,       1, 32'h102,      32'hC);
        tbl[8]  = mk(1, 0, 32'h0,        1, 0, 32'h10,       1, 32'h102,      32'hC);
        tbl[9]  = mk(0, 0, 32'h0,        1, 0, 32'h10,       1, 32'h103,      32'h10);
        tbl[10] = mk(0, 0, 32'h0,        1, 1, 32'h10,       1, 32'h104,      32'h14);
        tbl[11] = mk(0, 1, 32'h43,       1, 1, 32'h14,       0, 32'h0,        32'h14);
        tbl[12] = mk(0, 0, 32'h0,        1, 1, 32'h40,       1, 32'h110,      32'h44);
        tbl[13] = mk(1, 0, 32'h0,        1, 1, 32'h44,       1, 32'h110,      32'h44);
        tbl[14] = mk(1, 1, 32'h80,       1, 0, 32'h48,       0, 32'h0,        32'h44);
        tbl[15] = mk(1, 0, 32'h0,        1, 1, 32'h80,       0, 32'h0,        32'h44);
        tbl[16] = mk(0, 0, 32'h0,        1, 0, 32'h84,       1, 32'h120,      32'h84);
        tbl[17] = mk(0, 0, 32'h0,        1, 1, 32'h84,       1, 32'h121,      32'h88);
        tbl[18] = mk(0, 1, 32'hFFFFFFFF, 1, 1, 32'h88,       0, 32'h0,        32'h88);
        tbl[19] = mk(0, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 1, 32'h400000FF, 32'h0);
        tbl[20] = mk(0, 0, 32'h0,        1, 1, 32'h0,        1, 32'h100,      32'h4);

        rst_n = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
        stall8 = 1'b0; redirect8 = 1'b0; redirect_pc8 = 8'h0; imem_ready8 = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_valid",  {31'h0, if_valid}, 32'h0);
        chk("rst_inst",   if_inst, 32'h0);
        chk("rst_opcode", {26'h0, if_opcode}, 32'h0);
        chk("rst_pc4",    if_pc4, 32'h0);
        chk("rst_req",    {31'h0, imem_req}, 32'h0);
        chk("rst_addr",   imem_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            stall = tbl[i].stall; redirect = tbl[i].redir;
            redirect_pc = tbl[i].rpc; imem_ready = tbl[i].ready;
            #1;
            chk($sformatf("vec%0d_req", i),  {31'h0, imem_req}, {31'h0, tbl[i].exp_req});
            chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].exp_addr);
            tick();
            chk($sformatf("vec%0d_valid", i),  {31'h0, if_valid}, {31'h0, tbl[i].exp_valid});
            chk($sformatf("vec%0d_inst", i),   if_inst, tbl[i].exp_inst);
            chk($sformatf("vec%0d_opcode", i), {26'h0, if_opcode}, {26'h0, tbl[i].exp_inst[31:26]});
            chk($sformatf("vec%0d_pc4", i),    if_pc4, tbl[i].exp_pc4);
        end
        redirect = 1'b0;

        // Reset arriving while the skid entry is full.
        stall = 1'b1; imem_ready = 1'b1;
        #1;
        chk("hold_entry_req", {31'h0, imem_req}, 32'h1);
        tick();
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        chk("hold_addr", imem_addr, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'h0, if_valid}, 32'h0);
        chk("midrst_inst",  if_inst, 32'h0);
        chk("midrst_pc4",   if_pc4, 32'h0);
        chk("midrst_req",   {31'h0, imem_req}, 32'h0);
        chk("midrst_addr",  imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        #1;
        chk("restart_start_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("restart_req",  {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);

        // 8-bit PC wraps from 0xFC to 0x00.
        redirect8 = 1'b1; redirect_pc8 = 8'hFC;
        tick();
        redirect8 = 1'b0;
        #1;
        chk("w8_req",  {31'h0, imem_req8}, 32'h1);
        chk("w8_addr", {24'h0, imem_addr8}, 32'hFC);
        tick();
        chk("w8_inst",  if_inst8, 32'h13F);
        chk("w8_pc4",   {24'h0, if_pc48}, 32'h0);
        chk("w8_valid", {31'h0, if_valid8}, 32'h1);
        chk("w8_next_addr", {24'h0, imem_addr8}, 32'h0);
        tick();
        chk("w8_inst2", if_inst8, 32'h100);
        chk("w8_pc4_2", {24'h0, if_pc48}, 32'h4);

        // Random stimulus against the model.
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            chk("rnd_valid",  {31'h0, if_valid}, {31'h0, m_valid});
            chk("rnd_inst",   if_inst, m_inst);
            chk("rnd_opcode", {26'h0, if_opcode}, {26'h0, m_inst[31:26]});
            chk("rnd_pc4",    if_pc4, m_pc4);
            stall      = ($urandom_range(0, 2) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            redirect   = ($urandom_range(0, 15) == 0);
            rpc_r      = $urandom;
            if ($urandom_range(0, 7) == 0) rpc_r = 32'hFFFFFFF0 | (rpc_r & 32'hF);
            redirect_pc = rpc_r;
            #1;
            chk("rnd_req",  {31'h0, imem_req}, {31'h0, m_req()});
            chk("rnd_addr", imem_addr, m_pc);
            model_step(stall, redirect, redirect_pc, imem_ready);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
